alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Round-robin arbiter and sequencer that shares one `simple_alu` instance among four requesters. Each requester presents 2-bit operands and a 2-bit opcode with a valid/ready handshake. The block grants one request at a time, drives the latched operands onto the ALU, and captures the 4-bit result and carry. It returns them on a single shared response channel tagged with the requester ID. The block sits between client logic and the combinational `simple_alu`, which stays outside this module and connects through the `alu_*` ports.

## Interface
- `NREQ`, 4, number of requesters; fixed at 4 for this revision.
- `IDW`, 2, width of the requester ID; NREQ <= 2**IDW.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  2*NREQ  operand A; requester i uses bits [2i+1:2i].
- `req_b`  in  2*NREQ  operand B; same packing as `req_a`.
- `req_ctrl`  in  2*NREQ  ALU opcode; same packing as `req_a`.
- `alu_a`, `alu_b`, `alu_ctrl`  out  2 each  registered drive to `simple_alu` A, B, ctrl.
- `alu_y`  in  4  ALU result.
- `alu_c`  in  1  ALU carry/flag.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_y`  out  4  captured `alu_y`.
- `rsp_c`  out  1  captured `alu_c`.
- `busy`  out  1  high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP. The reset state is IDLE.
- **IDLE**
  - The grant is the first i with `req_valid[i]=1`, scanning from `ptr` upward modulo NREQ.
  - `req_ready[grant]=1` combinationally; all other ready bits are 0.
  - If no request is valid, `req_ready` is 0 and the state holds.
  - On the handshake edge:
    - latch a, b and ctrl into `alu_a`, `alu_b`, `alu_ctrl`;
    - latch the grant into `rsp_id`;
    - set `ptr = (grant+1) mod NREQ`;
    - go to EXEC.
- **EXEC** (exactly one cycle)
  - `alu_*` are stable, and `req_ready` is 0.
  - At the end of the cycle, capture `alu_y` into `rsp_y` and `alu_c` into `rsp_c`, then go to RESP.
- **RESP**
  - `rsp_valid=1`, and `rsp_id`, `rsp_y`, `rsp_c`, `alu_*` are held stable.
  - When `rsp_valid & rsp_ready` on an edge, go to IDLE and drop `rsp_valid`.
  - Otherwise hold indefinitely (backpressure). `req_ready` stays 0.
- **Arbitration rules**
  - `ptr` resets to 0.
  - A requester that is granted moves to lowest priority.
  - A requester that holds `req_valid` is served within NREQ grants.
- **Passthrough**
  - No arithmetic is done here.
  - `rsp_y` and `rsp_c` are bit-exact copies of the ALU outputs sampled in EXEC.
  - Opcode values pass through unchanged. Opcode 2'b11 with B=0 is forwarded like any other opcode.
- **Reset** (asynchronous, any state): `rst_n` low at any time forces state IDLE and `ptr` to 0. All outputs go low at once, and any in-flight or unaccepted response is discarded.
- `req_ready` is forced to 0 while `rst_n` is low.

## Timing
- Reset values:
  - `req_ready=0`, `alu_a=0`, `alu_b=0`, `alu_ctrl=0`;
  - `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`, `rsp_c=0`, `busy=0`.
- Handshake at edge T0 (IDLE→EXEC):
  - `alu_*` and `busy=1` are valid after T0.
  - The result is captured at T1, and `rsp_valid=1` after T1.
- Minimum issue interval: response accepted at T2 (→IDLE), next request accepted at T3. Peak throughput is one operation per 3 cycles.
- Latency from request accept to `rsp_valid` is 2 cycles.
- `req_valid` dropping in IDLE without a handshake is legal: no grant is made and `ptr` is unchanged.
- Requesters must hold their operands only until their handshake edge.
- A new `req_valid` arriving during EXEC or RESP waits and is arbitrated on return to IDLE.
- `rsp_ready` held high constantly gives a 3-cycle loop. `rsp_ready` high outside RESP is ignored.

## Test plan
- **Single request, no backpressure:** after reset, set `req_valid=4'b0001` with requester 0 a=2'b10, b=2'b01, ctrl=2'b00, and `rsp_ready=1`.
  - `req_ready=4'b0001` in the same cycle.
  - `alu_a=2'b10`, `alu_b=2'b01`, `alu_ctrl=2'b00` one cycle later.
  - With the real `simple_alu` attached, `rsp_valid=1` two cycles later with `rsp_id=0`, and `rsp_y`, `rsp_c` match the ALU model (2+1 → `rsp_y=4'h3`, `rsp_c=0`).
- **Round robin:** hold `req_valid=4'b1111` with `rsp_ready=1` for 12 operations.
  - Grant order is 0,1,2,3,0,1,2,3,…
  - Accepts are exactly 3 cycles apart.
  - Each `rsp_id` matches its grant.
- **Backpressure:** issue one request with `rsp_ready=0` for 5 cycles.
  - `rsp_valid`, `rsp_id`, `rsp_y`, `rsp_c`, `alu_*` stay constant.
  - `req_ready=0` although requester 2 is valid.
  - Raise `rsp_ready`: IDLE next, and requester 2 is granted on the following cycle.
- **Opcode sweep:** requester 3 issues a=2'b10 with (b,ctrl) = (01,00), (01,01), (10,10), (01,11), (00,11).
  - `rsp_y` and `rsp_c` equal the ALU model result for each, with `rsp_id=3`.
  - The B=0 divide case completes with no hang.
- **Reset mid-operation:** assert `rst_n=0` asynchronously during RESP.
  - All outputs go 0 immediately, with no `rsp_valid` pulse.
  - After release with `req_valid=4'b0110`, requester 1 is granted first (`ptr`=0).

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter/sequencer that shares one external
// combinational ALU among NREQ requesters. A granted request is latched onto
// the ALU inputs, its result is captured one cycle later, and it is returned
// on a single ID-tagged response channel with valid/ready backpressure.
module alu_share_ctrl #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [2*NREQ-1:0] req_a_i,
    input  logic [2*NREQ-1:0] req_b_i,
    input  logic [2*NREQ-1:0] req_ctrl_i,
    output logic [1:0]        alu_a_o,
    output logic [1:0]        alu_b_o,
    output logic [1:0]        alu_ctrl_o,
    input  logic [3:0]        alu_y_i,
    input  logic              alu_c_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [3:0]        rsp_y_o,
    output logic              rsp_c_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_next_s;
    logic [IDW-1:0] grant_s;
    logic           grant_vld_s;
    logic           accept_s;
    logic [1:0]     alu_a_q, alu_b_q, alu_ctrl_q;
    logic [IDW-1:0] rsp_id_q;
    logic [3:0]     rsp_y_q;
    logic           rsp_c_q;

    // Round-robin search: first valid requester starting at ptr, wrapping mod NREQ.
    always_comb begin
        logic [IDW:0] idx_v;
        idx_v       = {(IDW+1){1'b0}};
        grant_s     = ptr_q;
        grant_vld_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx_v >= (IDW+1)'(NREQ)) begin
                idx_v = idx_v - (IDW+1)'(NREQ);
            end else begin
                idx_v = idx_v;
            end
            if (!grant_vld_s && req_valid_i[idx_v[IDW-1:0]]) begin
                grant_s     = idx_v[IDW-1:0];
                grant_vld_s = 1'b1;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    assign accept_s   = (state_q == ST_IDLE) && grant_vld_s;
    // The granted requester drops to lowest priority.
    assign ptr_next_s = (grant_s == IDW'(NREQ - 1)) ? IDW'(0) : grant_s + IDW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> one EXEC cycle -> RESP until the response is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE toward the grant, and never while in reset.
    always_comb begin
        req_ready_o = {NREQ{1'b0}};
        if ((state_q == ST_IDLE) && grant_vld_s && rst_n) begin
            req_ready_o = NREQ'(1) << grant_s;
        end else begin
            req_ready_o = {NREQ{1'b0}};
        end
        rsp_valid_o = (state_q == ST_RESP);
        busy_o      = (state_q != ST_IDLE);
    end

    // Datapath: latch operands/ID/pointer on accept, capture ALU result during EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IDW'(0);
            alu_a_q    <= 2'b00;
            alu_b_q    <= 2'b00;
            alu_ctrl_q <= 2'b00;
            rsp_id_q   <= IDW'(0);
            rsp_y_q    <= 4'h0;
            rsp_c_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_a_q    <= req_a_i[{grant_s, 1'b0} +: 2];
                alu_b_q    <= req_b_i[{grant_s, 1'b0} +: 2];
                alu_ctrl_q <= req_ctrl_i[{grant_s, 1'b0} +: 2];
                rsp_id_q   <= grant_s;
                ptr_q      <= ptr_next_s;
            end
            if (state_q == ST_EXEC) begin
                rsp_y_q <= alu_y_i;
                rsp_c_q <= alu_c_i;
            end
        end
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_ctrl_o = alu_ctrl_q;
    assign rsp_id_o   = rsp_id_q;
    assign rsp_y_o    = rsp_y_q;
    assign rsp_c_o    = rsp_c_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl with a behavioural simple_alu attached.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid, req_ready;
    logic [7:0] req_a, req_b, req_ctrl;
    logic [1:0] alu_a, alu_b, alu_ctrl;
    logic [3:0] alu_y;
    logic       alu_c;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_id;
    logic [3:0] rsp_y;
    logic       rsp_c, busy;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;
    int cyc      = 0;

    alu_share_ctrl #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_ctrl_i(req_ctrl),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl),
        .alu_y_i(alu_y), .alu_c_i(alu_c),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_y_o(rsp_y), .rsp_c_o(rsp_c),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // simple_alu behaviour: {carry, y}
    function automatic logic [4:0] model_alu(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] op);
        int   ia, ib, r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        case (op)
            2'b00:   begin r = ia + ib; c = (r > 3); end
            2'b01:   begin r = ia - ib; c = (ia < ib); end
            2'b10:   begin r = ia * ib; c = (r > 3); end
            default: begin
                if (ib == 0) begin r = 15; c = 1'b1; end
                else begin r = ia / ib; c = ((ia % ib) != 0); end
            end
        endcase
        return {c, 4'(r)};
    endfunction

    // Round-robin reference: first valid index scanning upward from p, modulo 4.
    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always_comb {alu_c, alu_y} = model_alu(alu_a, alu_b, alu_ctrl);

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
        req_a = 8'hFF; req_b = 8'hFF; req_ctrl = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_y, rsp_c, busy} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_y, rsp_c, busy});
        end
        req_valid = 4'b0000; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_ptr = 0;
    endtask

    task automatic test_single;
        req_valid = 4'b0001; req_a = 8'h02; req_b = 8'h01; req_ctrl = 8'h00; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000; m_ptr = 1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl, busy, rsp_valid} !== {2'b10, 2'b01, 2'b00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_alu_drive: got %b expected 1001001_0",
                     {alu_a, alu_b, alu_ctrl, busy, rsp_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_c} !== {1'b1, 2'd0, 4'h3, 1'b0}) begin
            failures++;
            $display("FAIL single_rsp: got v=%b id=%0d y=%h c=%b expected v=1 id=0 y=3 c=0",
                     rsp_valid, rsp_id, rsp_y, rsp_c);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL single_accept: got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_round_robin;
        int g, w, last;
        logic [4:0] exp;
        last = 0;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int op = 0; op < 12; op++) begin
            req_a = 8'($urandom); req_b = 8'($urandom); req_ctrl = 8'($urandom);
            @(negedge clk);
            w = 0;
            while (req_ready == 4'b0000 && w < 10) begin @(negedge clk); w++; end
            g = model_grant(req_valid, m_ptr);
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                failures++; $display("FAIL rr_grant op%0d: got %b expected %b", op, req_ready, 4'(1 << g));
            end
            if (op > 0) begin
                checks++;
                if (cyc - last != 3) begin
                    failures++; $display("FAIL rr_interval op%0d: got %0d expected 3", op, cyc - last);
                end
            end
            last = cyc;
            exp = model_alu(req_a[2*g +: 2], req_b[2*g +: 2], req_ctrl[2*g +: 2]);
            @(posedge clk); #1;
            m_ptr = (g + 1) % 4;
            w = 0;
            while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
            checks++;
            if ({rsp_valid, rsp_id, rsp_c, rsp_y} !== {1'b1, 2'(g), exp}) begin
                failures++;
                $display("FAIL rr_rsp op%0d: got v=%b id=%0d cy=%h expected v=1 id=%0d cy=%h",
                         op, rsp_valid, rsp_id, {rsp_c, rsp_y}, g, exp);
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_opcode_sweep;
        logic [1:0] sw_b [5];
        logic [1:0] sw_c [5];
        logic [4:0] exp;
        int w;
        sw_b = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
        sw_c = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_a = 8'($urandom); req_b = 8'($urandom); req_ctrl = 8'($urandom);
            req_a[7:6] = 2'b10; req_b[7:6] = sw_b[i]; req_ctrl[7:6] = sw_c[i];
            req_valid = 4'b1000;
            exp = model_alu(2'b10, sw_b[i], sw_c[i]);
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b1000) begin
                failures++; $display("FAIL sweep_ready %0d: got %b expected 1000", i, req_ready);
            end
            @(posedge clk); #1;
            req_valid = 4'b0000; m_ptr = 0;
            w = 0;
            while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
            checks++;
            if ({rsp_valid, rsp_id, rsp_c, rsp_y} !== {1'b1, 2'd3, exp}) begin
                failures++;
                $display("FAIL sweep_rsp %0d: got v=%b id=%0d cy=%h expected v=1 id=3 cy=%h",
                         i, rsp_valid, rsp_id, {rsp_c, rsp_y}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [4:0]  exp, exp2;
        logic [13:0] snap_exp;
        int w;
        req_a = 8'($urandom); req_b = 8'($urandom); req_ctrl = 8'($urandom);
        req_valid = 4'b0010; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_ready: got %b expected 0010", req_ready);
        end
        exp = model_alu(req_a[3:2], req_b[3:2], req_ctrl[3:2]);
        snap_exp = {2'd1, exp[3:0], exp[4], req_a[3:2], req_b[3:2], req_ctrl[3:2], 1'b1};
        @(posedge clk); #1;
        m_ptr = 2;
        req_valid = 4'b0100;
        req_a = 8'($urandom); req_b = 8'($urandom); req_ctrl = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_id, rsp_y, rsp_c, alu_a, alu_b, alu_ctrl, rsp_valid} !== snap_exp) begin
                failures++;
                $display("FAIL bp_hold %0d: got %h expected %h", i,
                         {rsp_id, rsp_y, rsp_c, alu_a, alu_b, alu_ctrl, rsp_valid}, snap_exp);
            end
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_ready_low %0d: got %b expected 0000", i, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        exp2 = model_alu(req_a[5:4], req_b[5:4], req_ctrl[5:4]);
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, req_ready} !== 6'b00_0100) begin
            failures++;
            $display("FAIL bp_release: got %b expected 000100", {rsp_valid, busy, req_ready});
        end
        @(posedge clk); #1;
        req_valid = 4'b0000; m_ptr = 3;
        w = 0;
        while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
        checks++;
        if ({rsp_valid, rsp_id, rsp_c, rsp_y} !== {1'b1, 2'd2, exp2}) begin
            failures++;
            $display("FAIL bp_second: got v=%b id=%0d cy=%h expected v=1 id=2 cy=%h",
                     rsp_valid, rsp_id, {rsp_c, rsp_y}, exp2);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] v;
        logic [4:0] exp;
        int g, w, stall;
        for (int op = 0; op < 20; op++) begin
            v = 4'($urandom_range(1, 15));
            req_valid = v;
            req_a = 8'($urandom); req_b = 8'($urandom); req_ctrl = 8'($urandom);
            @(negedge clk);
            g = model_grant(v, m_ptr);
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                failures++;
                $display("FAIL rnd_grant op%0d: v=%b got %b expected %b", op, v, req_ready, 4'(1 << g));
            end
            exp = model_alu(req_a[2*g +: 2], req_b[2*g +: 2], req_ctrl[2*g +: 2]);
            @(posedge clk); #1;
            m_ptr = (g + 1) % 4;
            w = 0;
            while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                checks++;
                if (req_ready !== 4'b0000) begin
                    failures++; $display("FAIL rnd_ready_low op%0d: got %b expected 0000", op, req_ready);
                end
                @(negedge clk);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_c, rsp_y} !== {1'b1, 2'(g), exp}) begin
                failures++;
                $display("FAIL rnd_rsp op%0d: got v=%b id=%0d cy=%h expected v=1 id=%0d cy=%h",
                         op, rsp_valid, rsp_id, {rsp_c, rsp_y}, g, exp);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid;
        int w;
        req_valid = 4'b0001; rsp_ready = 1'b0;
        req_a = 8'hFF; req_b = 8'hFF; req_ctrl = 8'h00;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        w = 0;
        while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++; $display("FAIL rmid_pre: got rsp_valid=%b expected 1", rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        req_valid = 4'b0110;
        #1;
        checks++;
        if ({req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_y, rsp_c, busy} !== 20'h00000) begin
            failures++;
            $display("FAIL rmid_outputs: got %h expected 00000",
                     {req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_y, rsp_c, busy});
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        m_ptr = 0;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b0_0010) begin
            failures++;
            $display("FAIL rmid_regrant: got %b expected 00010", {rsp_valid, req_ready});
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        checks++;
        if ({busy, rsp_valid, rsp_id} !== 4'b1_0_01) begin
            failures++;
            $display("FAIL rmid_after: got %b expected 1001", {busy, rsp_valid, rsp_id});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'b0000; rsp_ready = 1'b0;
        req_a = 8'h00; req_b = 8'h00; req_ctrl = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_opcode_sweep();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
